// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit -- Coprocessor-0 register block for the multicycle MIPS core.
//
// Holds SR (IM/EXL/IE), Cause (IP), EPC and PRId. It samples the six hardware
// interrupt lines into Cause.IP and raises intReq when an unmasked, enabled
// line is pending outside the handler. The controller uses exlset/intctr on
// handler entry and exlclr on eret. mfc0/mtc0 go through sel/dout/din/we.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   sel     : CP0 register number (instr[15:11])
//   din     : mtc0 write data
//   we      : mtc0 write strobe
//   pc      : return address captured into EPC on intctr
//   hwint   : device interrupt lines, level-sensitive, active-high
//   exlset  : handler entry, sets SR.EXL
//   intctr  : handler entry with EPC capture (always together with exlset)
//   exlclr  : eret, clears SR.EXL
//   dout    : mfc0 read data, combinational from sel
//   epc     : current EPC for the eret next-PC mux
//   intReq  : interrupt request to the controller
// -----------------------------------------------------------------------------
module cp0_unit #(
  parameter logic [31:0] PRID      = 32'h0000_0061,
  parameter int          EPC_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic [5:0]  hwint,
  input  logic        exlset,
  input  logic        intctr,
  input  logic        exlclr,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        intReq
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]           im_q;
  logic                 exl_q;
  logic                 ie_q;
  logic [5:0]           ip_q;
  logic [EPC_WIDTH-1:0] epc_q;

  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] epc_ext;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign sr_wr  = we && (sel == REG_SR);
  assign epc_wr = we && (sel == REG_EPC);

  // EPC is word-aligned, so the low two return-address bits are never stored.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      ip_q  <= '0;
      epc_q <= '0;
    end else begin
      // Cause.IP is a plain registered copy of the lines; nothing is sticky.
      ip_q <= hwint;

      // NOTE: with non-blocking assignments the last assignment in program
      // order wins, so the statement order below encodes same-cycle priority:
      // SR write < exlclr < exlset for EXL, and mtc0 < intctr for EPC.
      if (sr_wr) begin
        im_q  <= din[15:10];
        exl_q <= din[1];
        ie_q  <= din[0];
      end
      if (exlclr) exl_q <= 1'b0;
      if (exlset) exl_q <= 1'b1;

      if (epc_wr) epc_q <= {din[EPC_WIDTH-1:2], 2'b00};
      if (intctr) epc_q <= {pc[EPC_WIDTH-1:2], 2'b00};
    end
  end

  // Zero-extend the stored EPC; works for any EPC_WIDTH up to 32.
  always_comb begin
    epc_ext                  = '0;
    epc_ext[EPC_WIDTH-1:0]   = epc_q;
  end

  assign sr_word    = {16'h0, im_q, 8'h0, exl_q, ie_q};
  assign cause_word = {16'h0, ip_q, 10'h0};

  // NOTE: every path assigns dout (default arm included), so no latch forms.
  always_comb begin
    case (sel)
      REG_SR:    dout = sr_word;
      REG_CAUSE: dout = cause_word;
      REG_EPC:   dout = epc_ext;
      REG_PRID:  dout = PRID;
      default:   dout = 32'h0;
    endcase
  end

  assign epc = epc_ext;

  // Built only from registered state, so the level cannot glitch.
  assign intReq = (|(ip_q & im_q)) & ie_q & ~exl_q;

endmodule
